// File: rtl/digit_scan_controller_pkg.sv
// Shared types and lookup helpers for the 4-digit 7-segment scan controller.
package digit_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } scan_state_e;

    localparam logic [7:0] ANODE_OFF = 8'hFF;

    function automatic logic [7:0] anode_pattern(input logic [1:0] sel);
        logic [7:0] pat;
        case (sel)
            2'd0:    pat = 8'hFE;
            2'd1:    pat = 8'hFD;
            2'd2:    pat = 8'hFB;
            default: pat = 8'hF7;
        endcase
        return pat;
    endfunction

    // A digit is a leading zero when it and every more significant digit are zero; ones never is.
    function automatic logic digit_suppressed(input logic [15:0] bcd, input logic [1:0] sel);
        logic sup;
        case (sel)
            2'd3:    sup = (bcd[15:12] == 4'h0);
            2'd2:    sup = (bcd[15:8] == 8'h00);
            2'd1:    sup = (bcd[15:4] == 12'h000);
            default: sup = 1'b0;
        endcase
        return sup;
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot counter and digit index for the scan controller; emits phase and frame strobes.
module scan_slot_timer #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_i,
    output logic [1:0] idx_next_o,
    output logic       blank_end_o,
    output logic       slot_end_o,
    output logic       frame_boundary_o
);

    localparam int CW = $clog2(TICKS_PER_DIGIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          running_q;
    logic          frame_d;

    assign slot_end_o  = running_q && (cnt_q == CW'(TICKS_PER_DIGIT - 1));
    assign blank_end_o = running_q && (cnt_q == CW'(BLANK_TICKS - 1));

    // The first enabled cycle after idle starts a fresh frame at slot 0, count 0.
    always_comb begin
        cnt_d   = '0;
        idx_d   = '0;
        frame_d = 1'b0;
        if (run_i) begin
            if (!running_q) begin
                frame_d = 1'b1;
            end else if (slot_end_o) begin
                idx_d   = idx_q + 2'd1;
                frame_d = (idx_q == 2'd3);
            end else begin
                cnt_d = cnt_q + CW'(1);
                idx_d = idx_q;
            end
        end
    end

    assign idx_next_o       = idx_d;
    assign frame_boundary_o = frame_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            running_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            running_q <= run_i;
        end
    end

endmodule

// File: rtl/digit_scan_controller.sv
// Time-multiplexed 4-digit 7-segment scan sequencer with frame-aligned value updates.
module digit_scan_controller
    import digit_scan_controller_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        lz_suppress,
    input  logic [15:0] bcd_in,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [7:0]  anode,
    output logic [3:0]  digit_bcd,
    output logic [1:0]  digit_sel,
    output logic        blank,
    output logic        frame_start
);

    scan_state_e state_q, state_d;

    logic [15:0] active_q, active_d;
    logic [15:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic        ready_q, ready_d;
    logic [7:0]  anode_q, anode_d;
    logic [3:0]  digit_bcd_q, digit_bcd_d;
    logic [1:0]  digit_sel_q;
    logic        blank_q, blank_d;
    logic        frame_start_q;

    logic [1:0]  idx_next;
    logic        blank_end;
    logic        slot_end;
    logic        frame_boundary;
    logic        drive;

    scan_slot_timer #(
        .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
        .BLANK_TICKS     (BLANK_TICKS)
    ) u_timer (
        .clk              (clk),
        .reset            (reset),
        .run_i            (enable),
        .idx_next_o       (idx_next),
        .blank_end_o      (blank_end),
        .slot_end_o       (slot_end),
        .frame_boundary_o (frame_boundary)
    );

    // Outputs are computed from next-cycle state so they line up with the slot being entered.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_BLANK;
                ST_BLANK: if (blank_end) state_d = ST_DRIVE;
                ST_DRIVE: if (slot_end) state_d = ST_BLANK;
                default:  state_d = ST_IDLE;
            endcase
        end

        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        if (frame_boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        // Ready reasserts one cycle after the commit, once pending_q has cleared.
        if (load_valid && ready_q) begin
            shadow_d  = bcd_in;
            pending_d = 1'b1;
            ready_d   = 1'b0;
        end else if (!pending_q) begin
            ready_d = 1'b1;
        end

        drive       = (state_d == ST_DRIVE) &&
                      !(lz_suppress && digit_suppressed(active_d, idx_next));
        anode_d     = drive ? anode_pattern(idx_next) : ANODE_OFF;
        blank_d     = !drive;
        digit_bcd_d = active_d[{idx_next, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            ready_q       <= 1'b1;
            anode_q       <= ANODE_OFF;
            digit_bcd_q   <= '0;
            digit_sel_q   <= '0;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            ready_q       <= ready_d;
            anode_q       <= anode_d;
            digit_bcd_q   <= digit_bcd_d;
            digit_sel_q   <= idx_next;
            blank_q       <= blank_d;
            frame_start_q <= frame_boundary;
        end
    end

    assign load_ready  = ready_q;
    assign anode       = anode_q;
    assign digit_bcd   = digit_bcd_q;
    assign digit_sel   = digit_sel_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Scoreboard bench for digit_scan_controller: frame-position reference model vs. DUT every cycle.
module tb_digit_scan_controller;

    localparam int T = 8;
    localparam int B = 2;

    typedef struct packed {
        logic [7:0] anode;
        logic [3:0] bcd;
        logic [1:0] sel;
        logic       blank;
        logic       fs;
        logic       ready;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [7:0]  anode;
    logic [3:0]  digit_bcd;
    logic [1:0]  digit_sel;
    logic        blank;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;

    obs_t exp_q[$];

    digit_scan_controller #(
        .TICKS_PER_DIGIT (T),
        .BLANK_TICKS     (B)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .lz_suppress (lz_suppress),
        .bcd_in      (bcd_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .anode       (anode),
        .digit_bcd   (digit_bcd),
        .digit_sel   (digit_sel),
        .blank       (blank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Reference model: position within a 4*T-cycle frame, plus the committed/pending values.
    bit          m_run = 0;
    int          m_t = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pending = 0;
    bit          m_ready = 1;
    bit          m_fs, m_commit, m_xfer, m_drive;
    int          m_sel, m_off;
    obs_t        m_exp;

    always @(posedge clk) begin
        m_fs = 0;
        m_commit = 0;
        if (reset) begin
            m_run = 0; m_t = 0; m_active = '0; m_shadow = '0;
            m_pending = 0; m_ready = 1;
        end else begin
            m_xfer = load_valid && m_ready;
            if (!enable) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0; m_fs = 1;
            end else begin
                m_t = (m_t + 1) % (4 * T);
                m_fs = (m_t == 0);
            end
            if (m_fs && m_pending) begin
                m_active = m_shadow; m_pending = 0; m_commit = 1;
            end
            if (m_xfer) begin
                m_shadow = bcd_in; m_pending = 1;
            end
            m_ready = !m_pending && !m_commit;
        end
        m_sel = m_run ? m_t / T : 0;
        m_off = m_t % T;
        m_drive = m_run && (m_off >= B) &&
                  !(lz_suppress && m_sel != 0 && (m_active >> (4 * m_sel)) == 16'h0);
        m_exp.anode = m_drive ? (8'hFF & ~(8'h01 << m_sel)) : 8'hFF;
        m_exp.bcd   = m_active[4 * m_sel +: 4];
        m_exp.sel   = 2'(m_sel);
        m_exp.blank = !m_drive;
        m_exp.fs    = m_fs;
        m_exp.ready = m_ready;
        exp_q.push_back(m_exp);
    end

    obs_t mon_exp, mon_act;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {anode, digit_bcd, digit_sel, blank, frame_start, load_ready};
            vectors++;
            if (mon_act !== mon_exp) begin
                miscompares++;
                $display("FAIL outputs @%0t: got anode=%h bcd=%h sel=%0d blank=%b fs=%b ready=%b, expected anode=%h bcd=%h sel=%0d blank=%b fs=%b ready=%b",
                         $time, mon_act.anode, mon_act.bcd, mon_act.sel, mon_act.blank, mon_act.fs, mon_act.ready,
                         mon_exp.anode, mon_exp.bcd, mon_exp.sel, mon_exp.blank, mon_exp.fs, mon_exp.ready);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v);
        bit done = 0;
        @(negedge clk);
        bcd_in = v;
        load_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (load_ready) done = 1;
            @(negedge clk);
        end
        load_valid = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL load_accept: got load_ready=0 for 200 cycles, expected 1 for value %h", v);
        end
    endtask

    task automatic wait_frame();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL frame_wait: got no frame_start in 200 cycles, expected one within %0d", 4 * T);
        end
    endtask

    bit taken;

    initial begin
        cycles(3);
        reset = 1'b0;
        cycles(2);

        load(16'h1234);
        enable = 1'b1;
        cycles(80);

        lz_suppress = 1'b1;
        load(16'h0007);
        cycles(70);
        load(16'h0000);
        cycles(70);

        lz_suppress = 1'b0;
        load(16'h1234);
        cycles(40);
        wait_frame();
        cycles(T + 3);
        load(16'h5678);
        cycles(70);

        wait_frame();
        cycles(2 * T + 3);
        enable = 1'b0;
        cycles(5);
        enable = 1'b1;
        cycles(40);

        wait_frame();
        load(16'h9999);
        cycles(2);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(40);
        lz_suppress = 1'b1;
        cycles(40);

        taken = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (taken) begin
                load_valid = 1'b0;
                taken = 0;
            end else if (load_valid) begin
                if (load_ready) taken = 1;
            end else if ($urandom_range(0, 5) == 0) begin
                bcd_in = 16'($urandom);
                if ($urandom_range(0, 2) == 0) bcd_in[15:8] = 8'h00;
                load_valid = 1'b1;
                taken = load_ready;
            end
            if (enable ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 7) == 0))
                enable = ~enable;
            if ($urandom_range(0, 59) == 0) lz_suppress = ~lz_suppress;
            if (i == 500) reset = 1'b1;
            if (i == 502) reset = 1'b0;
        end
        load_valid = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
